int16_to_fp16: RTL and testbench

INT16_TO_FP16 -- requirements
Module: int16_to_fp16

---
 rtl/fp16_pkg.sv | 30 +++
 rtl/fp16_rounder.sv | 26 ++
 rtl/int16_to_fp16.sv | 128 ++++++++++++
 tb/tb_int16_to_fp16.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared constants, FSM state and flag types for the int16 -> IEEE-754 half converter.
package fp16_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;
  localparam int unsigned INT_W    = 16;

  // Exponent of a magnitude whose MSB already sits in bit 15.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + INT_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } state_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic cout;
    logic inf;
    logic subnormal;
    logic nan;
  } flags_t;

endpackage

// File: rtl/fp16_rounder.sv
// Combinational round-to-nearest-even of a 10-bit mantissa with exponent carry.
module fp16_rounder
  import fp16_pkg::*;
(
  input  logic [MAN_W-1:0] mant_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [MAN_W-1:0] mant_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             inexact_o
);

  logic           round_up;
  logic [MAN_W:0] mant_sum;

  always_comb begin
    round_up  = guard_i & (sticky_i | mant_i[0]);
    mant_sum  = {1'b0, mant_i} + (MAN_W + 1)'(round_up);
    // A carry out leaves the low bits at zero, which is the cleared mantissa.
    mant_o    = mant_sum[MAN_W-1:0];
    exp_o     = exp_i + EXP_W'(mant_sum[MAN_W]);
    inexact_o = guard_i | sticky_i;
  end

endmodule

// File: rtl/int16_to_fp16.sv
// Multi-cycle signed 16-bit integer to half-precision converter with valid/ready handshakes.
module int16_to_fp16
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        cout,
  output logic        inf,
  output logic        subnormal,
  output logic        nan
);

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [15:0]      mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [15:0]      result_q, result_d;
  flags_t           flags_q, flags_d;

  logic [15:0]      in_abs;
  logic [15:0]      mag_shl;
  logic [MAN_W-1:0] rnd_mant;
  logic [EXP_W-1:0] rnd_exp;
  logic             rnd_inexact;

  // -32768 negates to itself, which reads correctly as unsigned 0x8000.
  assign in_abs  = in_data[15] ? (~in_data + 16'd1) : in_data;
  assign mag_shl = {mag_q[14:0], 1'b0};

  fp16_rounder u_rounder (
    .mant_i    (mag_q[14:5]),
    .guard_i   (mag_q[4]),
    .sticky_i  (|mag_q[3:0]),
    .exp_i     (exp_q),
    .mant_o    (rnd_mant),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    result_d  = result_q;
    flags_d   = flags_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_data[15];
          mag_d  = in_abs;
          exp_d  = EXP_INIT;
          if (in_abs == 16'd0) begin
            result_d     = 16'h0000;
            flags_d      = '0;
            flags_d.zero = 1'b1;
            state_d      = StDone;
          end else if (in_abs[15]) begin
            state_d = StRound;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (!mag_q[15]) begin
          mag_d = mag_shl;
          exp_d = exp_q - EXP_W'(1);
          // Leave as soon as the shift lands the MSB, saving an idle NORM edge.
          if (mag_q[14]) state_d = StRound;
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        result_d         = {sign_q, rnd_exp, rnd_mant};
        flags_d          = '0;
        flags_d.negative = sign_q;
        flags_d.cout     = rnd_inexact;
        state_d          = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      mag_q    <= 16'd0;
      exp_q    <= '0;
      result_q <= 16'd0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign out_data  = result_q;
  assign negative  = flags_q.negative;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;
  assign cout      = flags_q.cout;
  assign inf       = flags_q.inf;
  assign subnormal = flags_q.subnormal;
  assign nan       = flags_q.nan;

endmodule

// File: tb/tb_int16_to_fp16.sv
// Self-checking bench: directed vector table, reset corner cases and randomized conversions.
module tb_int16_to_fp16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        negative, zero, overflow, cout, inf, subnormal, nan;

  int checks   = 0;
  int failures = 0;

  int unsigned  max_lat = 40;

  always #5 clk = ~clk;

  int16_to_fp16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .cout      (cout),
    .inf       (inf),
    .subnormal (subnormal),
    .nan       (nan)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic [6:0]  flags;  // {negative, zero, overflow, cout, inf, subnormal, nan}
    int          lat;
  } vec_t;

  function automatic logic [6:0] dut_flags();
    return {negative, zero, overflow, cout, inf, subnormal, nan};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the value, rounding on the discarded remainder.
  function automatic void model(input logic [15:0] x, output logic [15:0] d,
                                output logic [6:0] f, output int lat);
    int v, m, p, e, frac, man, sh, rem, half;
    bit s;
    v = int'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) begin
      d = 16'h0000; f = 7'h20; lat = 1;
      return;
    end
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e    = p + 15;
    frac = m - (1 << p);
    rem  = 0;
    if (p <= 10) begin
      man = frac << (10 - p);
    end else begin
      sh   = p - 10;
      man  = frac >> sh;
      rem  = frac % (1 << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (man % 2) == 1)) man++;
    end
    if (man == 1024) begin
      man = 0;
      e++;
    end
    d   = {s, e[4:0], man[9:0]};
    f   = {s, 2'b00, (rem != 0), 3'b000};
    lat = 17 - p;
  endfunction

  // Entered and left just after a falling edge with in_valid low.
  task automatic do_conv(input logic [15:0] x, input logic [15:0] ed, input logic [6:0] ef,
                         input int el, input int hold, input string nm);
    int lat;
    chk({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    lat      = 1;
    while (!out_valid && lat < max_lat) begin
      @(negedge clk);
      lat++;
      if (lat > 1 && !out_valid) begin
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " out_data"}, 32'(out_data), 32'(ed));
    chk({nm, " flags"}, 32'(dut_flags()), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      @(negedge clk);
      chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold_ready"}, 32'(in_ready), 32'd0);
      chk({nm, " hold_data"}, 32'(out_data), 32'(ed));
      chk({nm, " hold_flags"}, 32'(dut_flags()), 32'(ef));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " retired"}, 32'(out_valid), 32'd0);
    chk({nm, " idle_after"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [15:0] md, x;
    logic [6:0]  mf;
    int          ml;
    bit          saw;

    vecs.push_back('{16'd1,     16'h3C00, 7'h00, 17});
    vecs.push_back('{16'h8000,  16'hF800, 7'h40, 2});
    vecs.push_back('{16'd0,     16'h0000, 7'h20, 1});
    vecs.push_back('{16'd2049,  16'h6800, 7'h08, 6});
    vecs.push_back('{16'd2051,  16'h6802, 7'h08, 6});
    vecs.push_back('{16'd32767, 16'h7800, 7'h08, 3});
    vecs.push_back('{16'hFFFF,  16'hBC00, 7'h40, 17});
    vecs.push_back('{16'd2048,  16'h6800, 7'h00, 6});
    vecs.push_back('{16'hF7FD,  16'hE802, 7'h48, 6});
    vecs.push_back('{16'd1000,  16'h63D0, 7'h00, 8});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    #3;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset flags", 32'(dut_flags()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First table entry is accepted on the first rising edge after release.
    foreach (vecs[i]) begin
      do_conv(vecs[i].din, vecs[i].dout, vecs[i].flags, vecs[i].lat, 0, $sformatf("vec%0d", i));
    end

    do_conv(16'd2051, 16'h6802, 7'h08, 6, 5, "hold5");

    // Reset during NORM discards the request.
    in_valid  = 1'b1;
    in_data   = 16'd1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw   = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("midrst no_output", 32'(saw), 32'd0);
    out_ready = 1'b0;
    do_conv(16'd1, 16'h3C00, 7'h00, 17, 0, "after_rst");

    for (int n = 0; n < 200; n++) begin
      x = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) x = -x;
      model(x, md, mf, ml);
      do_conv(x, md, mf, ml, $urandom_range(0, 3), $sformatf("rand%0d_%04h", n, x));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
